// File: rtl/simple_uart_rx.sv
// simple_uart_rx: 8N1 serial receiver with a single-byte holding buffer.
//   clk      in   clock, rising edge
//   resetn   in   synchronous active-low reset
//   i_rx     in   serial receive line, idle high
//   i_period in   bit period in clock cycles (already clamped to >= 2)
//   i_re     in   read strobe, clears o_valid
//   o_data   out  last completed byte
//   o_valid  out  o_data holds an unread byte
module simple_uart_rx (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_rx,
  input  logic [31:0] i_period,
  input  logic        i_re,
  output logic [7:0]  o_data,
  output logic        o_valid
);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_START = 4'd1;
  localparam logic [3:0] ST_DATA0 = 4'd2;
  localparam logic [3:0] ST_DATA7 = 4'd9;
  localparam logic [3:0] ST_STOP  = 4'd10;

  logic [3:0]  r_state;
  logic [31:0] r_cnt;
  logic [7:0]  r_byte;
  logic [7:0]  r_buf;
  logic        r_valid;
  logic [31:0] w_half;
  logic        w_bit_end;
  logic        w_done;

  assign w_half    = i_period >> 1;
  assign w_bit_end = (r_cnt >= i_period - 32'd1);
  // A completing byte takes priority over a read in the same cycle.
  assign w_done    = (r_state == ST_STOP) && w_bit_end;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_byte  <= '0;
      r_buf   <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_done) begin
        r_buf   <= r_byte;
        r_valid <= 1'b1;
      end else if (i_re) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (!i_rx) r_state <= ST_START;
        end
        ST_START: begin
          // Sample near the middle of the start bit; a high line here is a glitch.
          if (r_cnt >= w_half - 32'd1) begin
            r_cnt   <= '0;
            r_state <= i_rx ? ST_IDLE : ST_DATA0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          if (r_state >= ST_DATA0 && r_state <= ST_DATA7) begin
            if (w_bit_end) begin
              r_cnt   <= '0;
              r_byte  <= {i_rx, r_byte[7:1]};
              r_state <= r_state + 4'd1;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end else begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign o_data  = r_buf;
  assign o_valid = r_valid;

endmodule

// File: rtl/simple_uart.sv
// simple_uart: register-mapped 8N1 UART with programmable baud divider.
//   clk          in   clock, rising edge
//   resetn       in   synchronous active-low reset
//   ser_tx       out  serial transmit line, idle high
//   ser_rx       in   serial receive line, idle high
//   reg_div_we   in   per-byte write enables for the divider
//   reg_div_di   in   divider write data
//   reg_div_do   out  current divider value
//   reg_dat_we   in   transmit write strobe (byte in reg_dat_di[7:0])
//   reg_dat_re   in   receive read strobe
//   reg_dat_di   in   transmit data
//   reg_dat_do   out  received byte zero-extended, or all ones if none
//   reg_dat_wait out  transmit write stalled
module simple_uart #(
  parameter logic [31:0] DEFAULT_DIV = 32'd1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ser_tx,
  input  logic        ser_rx,
  input  logic [3:0]  reg_div_we,
  input  logic [31:0] reg_div_di,
  output logic [31:0] reg_div_do,
  input  logic        reg_dat_we,
  input  logic        reg_dat_re,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait
);

  localparam logic [3:0] FRAME_BITS = 4'd10;
  localparam logic [3:0] DUMMY_BITS = 4'd15;

  logic [31:0] r_div;
  logic [9:0]  r_tx_shift;
  logic [3:0]  r_tx_bitcnt;
  logic [31:0] r_tx_cnt;
  logic        r_tx_dummy;
  logic [31:0] w_period;
  logic        w_tx_busy;
  logic [7:0]  w_rx_data;
  logic        w_rx_valid;
  logic        w_unused_di;

  assign w_unused_di = ^reg_dat_di[31:8];
  assign w_period    = (r_div < 32'd2) ? 32'd2 : r_div;
  assign w_tx_busy   = (r_tx_bitcnt != 4'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_div <= DEFAULT_DIV;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (reg_div_we[i]) r_div[8*i +: 8] <= reg_div_di[8*i +: 8];
      end
    end
  end

  // Bit counter doubles as busy flag; the shift register refills with ones so
  // the line returns high after the stop bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tx_shift  <= '1;
      r_tx_bitcnt <= '0;
      r_tx_cnt    <= '0;
      r_tx_dummy  <= 1'b1;
    end else begin
      if (!w_tx_busy && r_tx_dummy) begin
        r_tx_shift  <= '1;
        r_tx_bitcnt <= DUMMY_BITS;
        r_tx_cnt    <= '0;
        r_tx_dummy  <= 1'b0;
      end else if (!w_tx_busy && reg_dat_we) begin
        r_tx_shift  <= {1'b1, reg_dat_di[7:0], 1'b0};
        r_tx_bitcnt <= FRAME_BITS;
        r_tx_cnt    <= '0;
      end else if (w_tx_busy) begin
        if (r_tx_cnt >= w_period - 32'd1) begin
          r_tx_shift  <= {1'b1, r_tx_shift[9:1]};
          r_tx_bitcnt <= r_tx_bitcnt - 4'd1;
          r_tx_cnt    <= '0;
        end else begin
          r_tx_cnt <= r_tx_cnt + 32'd1;
        end
      end
      // Placed last so a divider write always re-arms the resync pattern.
      if (|reg_div_we) r_tx_dummy <= 1'b1;
    end
  end

  simple_uart_rx u_rx (
    .clk      (clk),
    .resetn   (resetn),
    .i_rx     (ser_rx),
    .i_period (w_period),
    .i_re     (reg_dat_re),
    .o_data   (w_rx_data),
    .o_valid  (w_rx_valid)
  );

  assign ser_tx       = r_tx_shift[0];
  assign reg_div_do   = r_div;
  assign reg_dat_wait = reg_dat_we && (w_tx_busy || r_tx_dummy);
  assign reg_dat_do   = w_rx_valid ? {24'd0, w_rx_data} : '1;

endmodule

// File: tb/tb_simple_uart.sv
module tb_simple_uart;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ser_tx;
  logic        ser_rx;
  logic [3:0]  reg_div_we;
  logic [31:0] reg_div_di;
  logic [31:0] reg_div_do;
  logic        reg_dat_we;
  logic        reg_dat_re;
  logic [31:0] reg_dat_di;
  logic [31:0] reg_dat_do;
  logic        reg_dat_wait;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simple_uart #(.DEFAULT_DIV(32'd1)) u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .ser_tx       (ser_tx),
    .ser_rx       (ser_rx),
    .reg_div_we   (reg_div_we),
    .reg_div_di   (reg_div_di),
    .reg_div_do   (reg_div_do),
    .reg_dat_we   (reg_dat_we),
    .reg_dat_re   (reg_dat_re),
    .reg_dat_di   (reg_dat_di),
    .reg_dat_do   (reg_dat_do),
    .reg_dat_wait (reg_dat_wait)
  );

  task automatic write_div(input logic [3:0] we, input logic [31:0] di);
    @(posedge clk); #1;
    reg_div_we = we;
    reg_div_di = di;
    @(posedge clk); #1;
    reg_div_we = 4'h0;
  endtask

  task automatic send_rx(input logic [7:0] b, input int unsigned p);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    @(posedge clk); #1;
    for (int unsigned i = 0; i < 10; i++) begin
      ser_rx = f[i];
      repeat (p) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; ser_rx = 1'b1;
    reg_div_we = 4'h0; reg_div_di = '0;
    reg_dat_we = 1'b0; reg_dat_re = 1'b0; reg_dat_di = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    n_cmp++; if (ser_tx !== 1'b1) begin n_err++; $display("FAIL reset_ser_tx: got %b expected 1", ser_tx); end
    n_cmp++; if (reg_div_do !== 32'd1) begin n_err++; $display("FAIL reset_div_do: got %h expected 00000001", reg_div_do); end
    n_cmp++; if (reg_dat_do !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_dat_do: got %h expected ffffffff", reg_dat_do); end
    n_cmp++; if (reg_dat_wait !== 1'b0) begin n_err++; $display("FAIL reset_wait_idle: got %b expected 0", reg_dat_wait); end
    // Dummy is pending/active after reset, so a write must stall.
    reg_dat_we = 1'b1;
    #1;
    n_cmp++; if (reg_dat_wait !== 1'b1) begin n_err++; $display("FAIL reset_wait_we: got %b expected 1", reg_dat_wait); end
    reg_dat_we = 1'b0;
  endtask

  task automatic test_tx();
    int unsigned n;
    logic        saw_low;
    logic [9:0]  pat;
    logic        exp_bit;
    pat = {1'b1, 8'h55, 1'b0};
    repeat (40) @(posedge clk);
    #1;
    reg_div_we = 4'hF; reg_div_di = 32'd4;
    @(posedge clk); #1;          // divider written, dummy pending
    reg_div_we = 4'h0;
    @(posedge clk); #1;          // dummy has started
    n_cmp++; if (reg_div_do !== 32'd4) begin n_err++; $display("FAIL tx_div_do: got %h expected 00000004", reg_div_do); end
    reg_dat_we = 1'b1; reg_dat_di = 32'h0000_0055;
    n = 0; saw_low = 1'b0;
    @(negedge clk);
    while (reg_dat_wait && n < 200) begin
      if (ser_tx !== 1'b1) saw_low = 1'b1;
      n++;
      @(negedge clk);
    end
    n_cmp++; if (n !== 60) begin n_err++; $display("FAIL tx_wait_cycles: got %0d expected 60", n); end
    n_cmp++; if (saw_low !== 1'b0) begin n_err++; $display("FAIL tx_dummy_high: got line low expected high"); end
    @(posedge clk); #1;
    reg_dat_we = 1'b0;
    for (int unsigned k = 0; k < 40; k++) begin
      @(negedge clk);
      exp_bit = pat[k / 4];
      n_cmp++;
      if (ser_tx !== exp_bit) begin
        n_err++; $display("FAIL tx_bit_cycle%0d: got %b expected %b", k, ser_tx, exp_bit);
      end
    end
    @(negedge clk);
    n_cmp++; if (ser_tx !== 1'b1) begin n_err++; $display("FAIL tx_idle_after: got %b expected 1", ser_tx); end
  endtask

  task automatic test_div_bytes();
    write_div(4'b0010, 32'h0000_1200);
    @(negedge clk);
    n_cmp++; if (reg_div_do !== 32'h0000_1204) begin n_err++; $display("FAIL div_byte_we: got %h expected 00001204", reg_div_do); end
  endtask

  task automatic test_rx();
    write_div(4'hF, 32'd8);
    send_rx(8'hA3, 8);
    @(negedge clk);
    n_cmp++; if (reg_dat_do !== 32'h0000_00A3) begin n_err++; $display("FAIL rx_byte_a3: got %h expected 000000a3", reg_dat_do); end
    @(posedge clk); #1 reg_dat_re = 1'b1;
    @(posedge clk); #1 reg_dat_re = 1'b0;
    @(negedge clk);
    n_cmp++; if (reg_dat_do !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rx_read_clear: got %h expected ffffffff", reg_dat_do); end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1 ser_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 ser_rx = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (reg_dat_do !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL glitch_no_byte: got %h expected ffffffff", reg_dat_do); end
    n_cmp++; if (u_dut.u_rx.r_state !== 4'd0) begin n_err++; $display("FAIL glitch_idle: got state %0d expected 0", u_dut.u_rx.r_state); end
  endtask

  task automatic test_back_to_back();
    send_rx(8'h11, 8);
    send_rx(8'h3C, 8);
    @(negedge clk);
    n_cmp++; if (reg_dat_do !== 32'h0000_003C) begin n_err++; $display("FAIL rx_overrun: got %h expected 0000003c", reg_dat_do); end
  endtask

  task automatic test_reset_midframe();
    int unsigned n;
    logic        saw_low;
    reg_dat_we = 1'b1; reg_dat_di = 32'h0000_0000;
    n = 0;
    @(negedge clk);
    while (reg_dat_wait && n < 1000) begin n++; @(negedge clk); end
    n_cmp++; if (reg_dat_wait !== 1'b0) begin n_err++; $display("FAIL mid_accept_timeout: got wait %b expected 0", reg_dat_wait); end
    @(posedge clk); #1 reg_dat_we = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++; if (ser_tx !== 1'b0) begin n_err++; $display("FAIL mid_frame_low: got %b expected 0", ser_tx); end
    #1 resetn = 1'b0;
    @(negedge clk);
    n_cmp++; if (ser_tx !== 1'b1) begin n_err++; $display("FAIL mid_reset_tx: got %b expected 1", ser_tx); end
    n_cmp++; if (reg_div_do !== 32'd1) begin n_err++; $display("FAIL mid_reset_div: got %h expected 00000001", reg_div_do); end
    n_cmp++; if (reg_dat_do !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mid_reset_dat: got %h expected ffffffff", reg_dat_do); end
    #1 resetn = 1'b1;
    saw_low = 1'b0;
    for (int unsigned k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ser_tx !== 1'b1) saw_low = 1'b1;
    end
    n_cmp++; if (saw_low !== 1'b0) begin n_err++; $display("FAIL mid_no_partial: got line low expected high"); end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_div_bytes();
    test_rx();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/simple_uart.md
SIMPLE_UART -- requirements
Module: simple_uart

Interface
REQ-001 Parameter DEFAULT_DIV, default 1, reset value of the baud divider register.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 resetn  in  1  reset, synchronous, active-low.
REQ-004 ser_tx  out  1  serial transmit line, idle high.
REQ-005 ser_rx  in  1  serial receive line, idle high.
REQ-006 reg_div_we  in  4  per-byte write enables for divider register.
REQ-007 reg_div_di  in  32  divider write data.
REQ-008 reg_div_do  out  32  current divider value.
REQ-009 reg_dat_we  in  1  write byte reg_dat_di[7:0] to transmitter.
REQ-010 reg_dat_re  in  1  read strobe; consumes received byte.
REQ-011 reg_dat_di  in  32  transmit data; only [7:0] used.
REQ-012 reg_dat_do  out  32  received byte zero-extended if valid, else 32'hFFFF_FFFF.
REQ-013 reg_dat_wait  out  1  stall: high when reg_dat_we asserted while transmitter busy.

Function
REQ-014 Divider: each cycle, for every i with reg_div_we[i]=1, divider[8i+7:8i] <= reg_div_di[8i+7:8i]; reg_div_do = divider combinationally.
REQ-015 Effective bit period P = max(divider, 2) clock cycles, 8N1 frame, LSB first.
REQ-016 Any divider write sets a pending "dummy" flag; transmitter, when idle, then drives 15 bit periods of high (line resync) before accepting data.
REQ-017 TX idle = no frame/dummy in progress; reg_dat_we while idle and no dummy pending loads frame {stop=1, data[7:0], start=0}; ser_tx = start bit from next cycle.
REQ-018 TX shifts one bit every P cycles; after stop bit completes, idle; ser_tx held high when idle.
REQ-019 reg_dat_wait = reg_dat_we && (frame or dummy in progress or dummy pending); write accepted only in the cycle reg_dat_wait=0.
REQ-020 RX FSM states: IDLE, START, DATA0..DATA7, STOP.
REQ-021 IDLE -> START when ser_rx=0; START waits P/2 (integer divide) cycles then samples: ser_rx=0 -> DATA0, ser_rx=1 -> IDLE (glitch rejected).
REQ-022 DATAn samples ser_rx after P cycles, shifts into byte MSB-first-in (LSB ends at bit 0), advances.
REQ-023 STOP after P cycles: store byte in rx buffer, set rx_valid, -> IDLE; stop-bit value not checked.
REQ-024 New completed byte overwrites buffer even if rx_valid already set (overrun silent).
REQ-025 reg_dat_re clears rx_valid next cycle; if byte completes same cycle, completion wins (rx_valid stays 1, new data).
REQ-026 Divider change mid-frame takes effect at next bit-timer compare; no frame abort.
REQ-027 reg_dat_re and reg_dat_we never stall; reg_dat_do is combinational from buffer.

Reset
REQ-028 On resetn=0 at clk edge: divider=DEFAULT_DIV, rx FSM IDLE, rx_valid=0, rx buffer=0, tx idle with dummy pending, ser_tx=1, all counters 0.
REQ-029 Outputs after reset: ser_tx=1, reg_div_do=DEFAULT_DIV, reg_dat_do=32'hFFFF_FFFF, reg_dat_wait=reg_dat_we.
REQ-030 Reset mid-frame aborts both directions immediately without emitting partial bits.

Structure
REQ-031 No shared package; frame length and state encodings are local constants.
REQ-032 Receiver is one sub-module simple_uart_rx; transmitter and divider register in top module.

Verification
REQ-033 Reset, reg_dat_we=0 -> ser_tx=1, reg_div_do=1, reg_dat_do=FFFF_FFFF.
REQ-034 Write divider 4 via reg_div_we=4'hF, then reg_dat_we with 0x55 -> wait high for 60 cycles of dummy, then start bit, bits 1,0,1,0,1,0,1,0, stop, each 4 cycles.
REQ-035 reg_div_we=4'b0010, di=0x0000_1200 on divider 4 -> reg_div_do=0x0000_1204.
REQ-036 Divider 8, drive 0xA3 frame on ser_rx -> rx_valid, reg_dat_do=0x0000_00A3; pulse reg_dat_re -> FFFF_FFFF.
REQ-037 ser_rx low for 2 cycles (P=8) -> no byte received, FSM back to IDLE.
REQ-038 Second byte 0x3C received without read -> reg_dat_do=0x0000_003C.
